// File: rtl/sync_pointer_fifo_if.sv
// Handshake, status and error signals between a producer/consumer pair and sync_pointer_fifo.
// master = the producer/consumer side, slave = the FIFO.
interface sync_pointer_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             fifo_f;
    logic             fifo_e;
    logic             fifo_af;
    logic             fifo_ae;
    logic [CW-1:0]    count;
    logic             clr_err;
    logic             ovf;
    logic             udf;

    modport master (
        output in_ready, data_in, out_ready, clr_err,
        input  data_out, out_valid, fifo_f, fifo_e, fifo_af, fifo_ae, count, ovf, udf
    );

    modport slave (
        input  in_ready, data_in, out_ready, clr_err,
        output data_out, out_valid, fifo_f, fifo_e, fifo_af, fifo_ae, count, ovf, udf
    );
endinterface

// File: rtl/sync_pointer_fifo.sv
// Single-clock pointer FIFO with AF/AE thresholds, occupancy count and sticky ovf/udf flags.
// Read latency 1 (registered data_out/out_valid); latency 0 when FIFO_FWFT_EN is defined.
// Writes while full are dropped (ovf), reads while empty are ignored (udf); flags are the backpressure.
module sync_pointer_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    sync_pointer_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_q;
    logic             udf_q;

    // All status flags decode the registered count, so they cannot glitch.
    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign wr_acc = bus.in_ready & ~full;
    assign rd_acc = bus.out_ready & ~empty;

    assign bus.fifo_f  = full;
    assign bus.fifo_e  = empty;
    assign bus.fifo_af = (cnt >= AF_CNT);
    assign bus.fifo_ae = (cnt <= AE_CNT);
    assign bus.count   = cnt;
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;

    always_ff @(posedge clk) begin
        if (wr_acc) mem[waddr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr <= '0;
            raddr <= '0;
            cnt   <= '0;
        end else begin
            if (wr_acc) waddr <= (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
            if (rd_acc) raddr <= (raddr == LAST_ADDR) ? '0 : raddr + 1'b1;
            if (wr_acc && !rd_acc)      cnt <= cnt + 1'b1;
            else if (rd_acc && !wr_acc) cnt <= cnt - 1'b1;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.in_ready && full) ovf_q <= 1'b1;
            else if (bus.clr_err)     ovf_q <= 1'b0;
            if (bus.out_ready && empty) udf_q <= 1'b1;
            else if (bus.clr_err)       udf_q <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out  = mem[raddr];
    assign bus.out_valid = ~empty;
`else
    logic [WIDTH-1:0] dout_q;
    logic             vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= rd_acc;
            if (rd_acc) dout_q <= mem[raddr];
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.out_valid = vld_q;
`endif
endmodule
